ex_mem_pipe: RTL and testbench

- EX/MEM pipeline register of the 16-bit 5-stage core. Sits between the execute stage and the data-memory/branch-resolve stage, and feeds that stage directly.
- Captures ALU result, store data, branch target, next PC, flags and control bits from execute.
- Implements stall (hold), flush (bubble insertion) and a halt sequencer. The sequencer guarantees the downstream memory sees exactly one halt/dump request, then drains to idle.

---
 rtl/ex_mem_pipe_pkg.sv | 18 +
 rtl/ex_mem_pipe_reg_en.sv | 26 ++
 rtl/ex_mem_pipe.sv | 138 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: halt sequencer state
// encodings and the branch condition select codes carried on branch_op.
package ex_mem_pipe_pkg;

  typedef enum logic [1:0] {
    HS_RUN  = 2'b00,
    HS_PEND = 2'b01,
    HS_DONE = 2'b10
  } halt_state_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } branch_op_e;

endpackage

// File: rtl/ex_mem_pipe_reg_en.sv
// Generic pipeline register slice: synchronous active-low reset, a
// synchronous clear that loads zeros (bubble), and a load enable. When
// neither clear nor enable is set the slice holds its contents.
module pipe_reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset beats clear, clear beats load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register of the 16-bit core. Captures execute-stage
// results and control, supports stall (hold) and flush (bubble), and runs a
// halt sequencer so the memory stage sees exactly one halt request before
// the pipe locks into a bubble-only HALTED state until reset.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_in,
  input  logic          zero_in,
  input  logic          ltz_in,
  input  logic          branch_in,
  input  logic [1:0]    branch_op_in,
  input  logic [DW-1:0] branch_addr_in,
  input  logic [DW-1:0] pc_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] write_data_in,
  input  logic          reg_write_in,
  input  logic [RW-1:0] write_reg_in,
  input  logic          mem_to_reg_in,
  input  logic          halt_in,
  output logic          valid,
  output logic          zero,
  output logic          ltz,
  output logic          branch,
  output logic [1:0]    branch_op,
  output logic [DW-1:0] branch_addr,
  output logic [DW-1:0] pc,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] write_data,
  output logic          reg_write,
  output logic [RW-1:0] write_reg,
  output logic          mem_to_reg,
  output logic          halt,
  output logic          halted
);

  localparam int CTRL_W = 9 + RW;

  halt_state_e state;
  logic        load_en;
  logic        clear;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [1:0]        flag_d;
  logic [1:0]        flag_q;

  // Decide per edge whether the register slices load, clear to a bubble, or
  // hold. A latched HALT cannot be flushed; only a stall delays its drain.
  always_comb begin
    load_en = 1'b0;
    clear   = 1'b0;
    unique case (state)
      HS_RUN: begin
        if (flush) begin
          clear = 1'b1;
        end else if (!stall) begin
          if (valid_in) begin
            load_en = 1'b1;
          end else begin
            clear = 1'b1;
          end
        end
      end
      HS_PEND: clear = !stall;
      HS_DONE: clear = 1'b1;
      default: clear = 1'b1;
    endcase
  end

  // Halt sequencer: RUN -> PEND when a valid HALT is loaded, PEND -> DONE
  // on the next un-stalled edge, DONE holds until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HS_RUN;
    end else begin
      unique case (state)
        HS_RUN: begin
          if (!flush && !stall && valid_in && halt_in) begin
            state <= HS_PEND;
          end
        end
        HS_PEND: begin
          if (!stall) begin
            state <= HS_DONE;
          end
        end
        HS_DONE: state <= HS_DONE;
        default: state <= HS_RUN;
      endcase
    end
  end

  assign halted = (state == HS_DONE);

  assign ctrl_d = {valid_in, branch_in, mem_read_in, mem_write_in, reg_write_in,
                   mem_to_reg_in, halt_in, branch_op_in, write_reg_in};
  assign {valid, branch, mem_read, mem_write, reg_write,
          mem_to_reg, halt, branch_op, write_reg} = ctrl_q;

  assign flag_d = {zero_in, ltz_in};
  assign {zero, ltz} = flag_q;

  pipe_reg_en #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_reg_en #(.W(2)) u_flags (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(flag_d), .q(flag_q)
  );

  pipe_reg_en #(.W(DW)) u_branch_addr (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(branch_addr_in), .q(branch_addr)
  );

  pipe_reg_en #(.W(DW)) u_pc (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(pc_in), .q(pc)
  );

  pipe_reg_en #(.W(DW)) u_alu_result (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(alu_result_in), .q(alu_result)
  );

  pipe_reg_en #(.W(DW)) u_write_data (
    .clk(clk), .rst(rst), .clr(clear), .en(load_en), .d(write_data_in), .q(write_data)
  );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: directed scenarios plus a randomized run, all
// checked against a behavioural model of the pipe register and halt sequence.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic        zero;
    logic        ltz;
    logic        branch;
    logic [1:0]  branch_op;
    logic [15:0] branch_addr;
    logic [15:0] pc;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] alu_result;
    logic [15:0] write_data;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic        mem_to_reg;
    logic        halt;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    stall;
  logic    flush;
  fields_t din;
  fields_t dout;
  fields_t exp_out;
  logic    exp_halted;
  int      model_phase;
  int      checks = 0;
  int      errors = 0;

  logic        q_valid, q_zero, q_ltz, q_branch, q_mem_read, q_mem_write;
  logic        q_reg_write, q_mem_to_reg, q_halt, q_halted;
  logic [1:0]  q_branch_op;
  logic [15:0] q_branch_addr, q_pc, q_alu_result, q_write_data;
  logic [2:0]  q_write_reg;

  assign dout = {q_valid, q_zero, q_ltz, q_branch, q_branch_op, q_branch_addr, q_pc,
                 q_mem_read, q_mem_write, q_alu_result, q_write_data, q_reg_write,
                 q_write_reg, q_mem_to_reg, q_halt};

  always #5 clk = ~clk;

  ex_mem_pipe #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(din.valid), .zero_in(din.zero), .ltz_in(din.ltz),
    .branch_in(din.branch), .branch_op_in(din.branch_op),
    .branch_addr_in(din.branch_addr), .pc_in(din.pc),
    .mem_read_in(din.mem_read), .mem_write_in(din.mem_write),
    .alu_result_in(din.alu_result), .write_data_in(din.write_data),
    .reg_write_in(din.reg_write), .write_reg_in(din.write_reg),
    .mem_to_reg_in(din.mem_to_reg), .halt_in(din.halt),
    .valid(q_valid), .zero(q_zero), .ltz(q_ltz), .branch(q_branch),
    .branch_op(q_branch_op), .branch_addr(q_branch_addr), .pc(q_pc),
    .mem_read(q_mem_read), .mem_write(q_mem_write), .alu_result(q_alu_result),
    .write_data(q_write_data), .reg_write(q_reg_write), .write_reg(q_write_reg),
    .mem_to_reg(q_mem_to_reg), .halt(q_halt), .halted(q_halted)
  );

  // Behavioural model. model_phase: 0 running, 1 halt latched and waiting
  // for one un-stalled cycle, 2 finished and locked until reset.
  task automatic model_step();
    if (!rst) begin
      exp_out = '0;
      model_phase = 0;
    end else if (model_phase == 2) begin
      exp_out = '0;
    end else if (model_phase == 1) begin
      if (!stall) begin
        exp_out = '0;
        model_phase = 2;
      end
    end else if (flush) begin
      exp_out = '0;
    end else if (!stall) begin
      if (din.valid) begin
        exp_out = din;
        if (din.halt) model_phase = 1;
      end else begin
        exp_out = '0;
      end
    end
    exp_halted = (model_phase == 2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    din = r[77:0];
  endtask

  task automatic test_reset();
    din = '1;
    stall = 1'b1;
    flush = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (dout !== 78'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0", dout);
    end
    checks++;
    if (q_halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_halted: got %b want 0", q_halted);
    end
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    tick();
    checks++;
    if (dout !== {78{1'b1}}) begin
      errors++;
      $display("[TB] FAIL reset_release_capture: got %h want all ones", dout);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_pass();
    din = '0;
    din.valid = 1'b1;
    din.alu_result = 16'h1234;
    din.write_data = 16'hBEEF;
    din.mem_write = 1'b1;
    tick();
    checks++;
    if (q_alu_result !== 16'h1234 || q_write_data !== 16'hBEEF || q_mem_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pass_store: got alu=%h wd=%h mw=%b want 1234 BEEF 1",
               q_alu_result, q_write_data, q_mem_write);
    end
    checks++;
    if (dout !== exp_out) begin
      errors++;
      $display("[TB] FAIL pass_model: got %h want %h", dout, exp_out);
    end
  endtask

  task automatic test_stall_flush();
    fields_t held;
    held = exp_out;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      din.halt = 1'b0;
      tick();
      checks++;
      if (dout !== held) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got %h want %h", i, dout, held);
      end
    end
    flush = 1'b1;
    randomize_inputs();
    din.valid = 1'b1;
    tick();
    checks++;
    if (q_mem_write !== 1'b0 || q_alu_result !== 16'h0 || dout !== 78'd0) begin
      errors++;
      $display("[TB] FAIL stall_flush_bubble: got %h want 0", dout);
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_invalid_gating();
    randomize_inputs();
    din.valid = 1'b0;
    din.branch = 1'b1;
    din.reg_write = 1'b1;
    din.mem_write = 1'b1;
    din.halt = 1'b1;
    tick();
    checks++;
    if (q_branch !== 1'b0 || q_reg_write !== 1'b0 || q_valid !== 1'b0 ||
        q_mem_write !== 1'b0 || q_halt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_gating: got v=%b br=%b rw=%b mw=%b h=%b want all 0",
               q_valid, q_branch, q_reg_write, q_mem_write, q_halt);
    end
    checks++;
    if (q_halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_no_halt: got halted=%b want 0", q_halted);
    end
  endtask

  task automatic test_halt_sequence();
    randomize_inputs();
    din.valid = 1'b1;
    din.halt = 1'b1;
    tick();
    checks++;
    if (q_halt !== 1'b1 || dout !== exp_out) begin
      errors++;
      $display("[TB] FAIL halt_capture: got %h want %h", dout, exp_out);
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      din.valid = 1'b1;
      din.halt = 1'b0;
      tick();
      checks++;
      if (q_halt !== 1'b1 || q_halted !== 1'b0) begin
        errors++;
        $display("[TB] FAIL halt_stalled[%0d]: got halt=%b halted=%b want 1 0", i, q_halt, q_halted);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      din.valid = 1'b1;
      din.mem_write = 1'b1;
      din.halt = 1'b0;
      flush = (i == 1);
      tick();
      checks++;
      if (dout !== 78'd0 || q_halted !== 1'b1) begin
        errors++;
        $display("[TB] FAIL halt_drained[%0d]: got %h halted=%b want 0 halted=1", i, dout, q_halted);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_recovery();
    rst = 1'b0;
    tick();
    checks++;
    if (q_halted !== 1'b0 || dout !== 78'd0) begin
      errors++;
      $display("[TB] FAIL recover_reset: got %h halted=%b want 0 halted=0", dout, q_halted);
    end
    rst = 1'b1;
    randomize_inputs();
    din.valid = 1'b1;
    din.halt = 1'b0;
    tick();
    checks++;
    if (dout !== exp_out || q_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL recover_load: got %h want %h", dout, exp_out);
    end
  endtask

  task automatic test_squash();
    randomize_inputs();
    din.valid = 1'b1;
    din.halt = 1'b1;
    flush = 1'b1;
    tick();
    checks++;
    if (q_halt !== 1'b0 || dout !== 78'd0) begin
      errors++;
      $display("[TB] FAIL squash_bubble: got %h want 0", dout);
    end
    flush = 1'b0;
    randomize_inputs();
    din.valid = 1'b1;
    din.halt = 1'b0;
    tick();
    checks++;
    if (dout !== exp_out || q_halted !== 1'b0 || q_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL squash_still_running: got %h halted=%b want %h halted=0",
               dout, q_halted, exp_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      din.halt  = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      rst       = !($urandom_range(0, 29) == 0);
      tick();
      checks++;
      if (dout !== exp_out || q_halted !== exp_halted) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %h halted=%b want %h halted=%b",
                 i, dout, q_halted, exp_out, exp_halted);
      end
    end
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    exp_out = '0;
    exp_halted = 1'b0;
    model_phase = 0;
    din = '0;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    test_reset();
    test_pass();
    test_stall_flush();
    test_invalid_gating();
    test_halt_sequence();
    test_reset_recovery();
    test_squash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
